// File: rtl/byte_word_packer.sv
// Packs an 8-bit valid/ready byte stream into 32-bit words with per-lane keep and packet-end flag.
// A word is emitted after four bytes or on in_last; a single output register decouples downstream stalls.
module byte_word_packer #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  data_in,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  out_keep,
  output logic        out_last
);

  logic [1:0]  count;
  logic [23:0] acc;

  logic        byte_xfer;
  logic        out_xfer;
  logic        word_done;
  logic [23:0] acc_next;
  logic [31:0] word_lanes;
  logic [31:0] word_mapped;
  logic [3:0]  keep_next;

  assign in_ready  = !out_valid || out_ready;
  assign byte_xfer = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign word_done = byte_xfer && (in_last || (count == 2'd3));

  // The accumulator keeps bytes in arrival order (byte k in acc[8k+:8]) and unused
  // lanes are always zero, so OR-ing the current byte in yields the complete word.
  always_comb begin
    word_lanes = {8'h00, acc} | ({24'h000000, data_in} << {count, 3'b000});

    keep_next = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      keep_next[k] = (k <= 32'(count));
    end

    word_mapped = word_lanes;
    if (BIG_ENDIAN) begin
      for (int unsigned k = 0; k < 4; k++) begin
        word_mapped[8*k +: 8] = word_lanes[8*(3-k) +: 8];
      end
    end

    acc_next = acc;
    case (count)
      2'd0:    acc_next[7:0]   = data_in;
      2'd1:    acc_next[15:8]  = data_in;
      2'd2:    acc_next[23:16] = data_in;
      default: acc_next        = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (word_done) begin
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b1;
      data_out  <= word_mapped;
      out_keep  <= keep_next;
      out_last  <= in_last;
    end else begin
      if (byte_xfer) begin
        count <= count + 2'd1;
        acc   <= acc_next;
      end
      if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench: two packers (little/big endian) share one stimulus stream and are
// compared every cycle against a queue-based packet model, plus literal spot checks.
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, out_last0;
  logic [31:0] data_out0;
  logic [3:0]  out_keep0;
  logic        in_ready1, out_valid1, out_last1;
  logic [31:0] data_out1;
  logic [3:0]  out_keep1;

  int checks = 0;
  int fails  = 0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  byte_word_packer #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .data_out(data_out0), .out_keep(out_keep0),
    .out_last(out_last0)
  );

  byte_word_packer #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .data_out(data_out1), .out_keep(out_keep1),
    .out_last(out_last1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted bytes of the current packet; a word is formed
  // from them when the packet ends or four bytes are gathered.
  logic [7:0] pend[$];
  logic [7:0] m_bytes[4];
  int         m_n = 0;
  logic       m_valid = 1'b0;
  logic       m_last = 1'b0;

  function automatic logic [31:0] exp_word(input logic big);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < m_n; k++) begin
      if (big) w = w + (32'(m_bytes[k]) << (24 - 8*k));
      else     w = w + (32'(m_bytes[k]) << (8*k));
    end
    return w;
  endfunction

  function automatic logic [3:0] exp_keep();
    return 4'((1 << m_n) - 1);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        m_n = 0;
        m_valid = 1'b0;
        m_last = 1'b0;
        for (int k = 0; k < 4; k++) m_bytes[k] = 8'h00;
      end else begin
        logic ready_m, done_m;
        ready_m = !m_valid || out_ready;
        done_m = 1'b0;
        if (in_valid && ready_m) begin
          pend.push_back(data_in);
          if (in_last || pend.size() == 4) begin
            m_n = pend.size();
            for (int k = 0; k < 4; k++) m_bytes[k] = (k < m_n) ? pend[k] : 8'h00;
            m_last = in_last;
            pend.delete();
            done_m = 1'b1;
          end
        end
        if (done_m) m_valid = 1'b1;
        else if (m_valid && out_ready) m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready_le", 32'(in_ready0), 32'(!m_valid || out_ready));
      chk("out_valid_le", 32'(out_valid0), 32'(m_valid));
      chk("data_out_le", data_out0, exp_word(1'b0));
      chk("out_keep_le", 32'(out_keep0), 32'(exp_keep()));
      chk("out_last_le", 32'(out_last0), 32'(m_last));
      chk("in_ready_be", 32'(in_ready1), 32'(!m_valid || out_ready));
      chk("out_valid_be", 32'(out_valid1), 32'(m_valid));
      chk("data_out_be", data_out1, exp_word(1'b1));
      chk("out_keep_be", 32'(out_keep1), 32'(exp_keep()));
      chk("out_last_be", 32'(out_last1), 32'(m_last));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one byte and hold it until accepted; returns aligned at posedge+2.
  task automatic send_byte(input logic [7:0] b, input logic last, output int waits,
                           output logic ov_seen);
    logic rdy;
    waits = 0;
    ov_seen = 1'b0;
    in_valid = 1'b1;
    data_in = b;
    in_last = last;
    forever begin
      @(negedge clk);
      rdy = in_ready0;
      ov_seen = out_valid0;
      @(posedge clk);
      #2;
      if (rdy) break;
      waits++;
      if (waits > 200) begin
        checks++;
        fails++;
        $display("FAIL send_timeout: byte %h not accepted after %0d cycles", b, waits);
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    data_in = 8'($urandom);
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int w, wsum;
    logic ov;
    logic [7:0] seq8 [8];

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    align();

    // Four bytes back-to-back, last on the fourth.
    wsum = 0;
    send_byte(8'h11, 1'b0, w, ov); wsum += w;
    send_byte(8'h22, 1'b0, w, ov); wsum += w;
    send_byte(8'h33, 1'b0, w, ov); wsum += w;
    send_byte(8'h44, 1'b1, w, ov); wsum += w;
    @(negedge clk);
    chk("t1_data", data_out0, 32'h44332211);
    chk("t1_keep", 32'(out_keep0), 32'hF);
    chk("t1_last", 32'(out_last0), 32'h1);
    chk("t1_no_stall", 32'(wsum), 32'h0);
    align();

    // Three-byte packet.
    send_byte(8'hAA, 1'b0, w, ov);
    send_byte(8'hBB, 1'b0, w, ov);
    send_byte(8'hCC, 1'b1, w, ov);
    @(negedge clk);
    chk("t2_data_be", data_out1, 32'hAABBCC00);
    chk("t2_keep_be", 32'(out_keep1), 32'h7);
    chk("t2_last_be", 32'(out_last1), 32'h1);
    chk("t2_data_le", data_out0, 32'h00CCBBAA);
    align();

    // Eight bytes with the downstream stalled after the first word.
    for (int i = 0; i < 8; i++) seq8[i] = 8'(i + 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(seq8[i], 1'b0, w, ov);
    fork
      begin
        for (int i = 4; i < 8; i++) send_byte(seq8[i], (i == 7), w, ov);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t3_hold_data", data_out0, 32'h04030201);
          chk("t3_hold_valid", 32'(out_valid0), 32'h1);
          chk("t3_hold_ready", 32'(in_ready0), 32'h0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("t3_second_data", data_out0, 32'h08070605);
    chk("t3_second_keep", 32'(out_keep0), 32'hF);
    chk("t3_second_last", 32'(out_last0), 32'h1);
    align();

    // Single-byte packet.
    send_byte(8'h5A, 1'b1, w, ov);
    @(negedge clk);
    chk("t4_data_le", data_out0, 32'h0000005A);
    chk("t4_keep", 32'(out_keep0), 32'h1);
    chk("t4_last", 32'(out_last0), 32'h1);
    chk("t4_data_be", data_out1, 32'h5A000000);
    align();

    // Completing byte on the same edge as the output handshake.
    send_byte(8'hC1, 1'b0, w, ov);
    send_byte(8'hC2, 1'b1, w, ov);
    send_byte(8'hD3, 1'b1, w, ov);
    chk("t5_valid_before", 32'(ov), 32'h1);
    @(negedge clk);
    chk("t5_valid_after", 32'(out_valid0), 32'h1);
    chk("t5_data", data_out0, 32'h000000D3);
    chk("t5_keep", 32'(out_keep0), 32'h1);
    align();

    // Reset in the middle of a packet.
    send_byte(8'h01, 1'b0, w, ov);
    send_byte(8'h02, 1'b0, w, ov);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", data_out0, 32'h0);
    chk("t6_rst_keep", 32'(out_keep0), 32'h0);
    chk("t6_rst_last", 32'(out_last0), 32'h0);
    chk("t6_rst_valid", 32'(out_valid0), 32'h0);
    chk("t6_rst_ready", 32'(in_ready0), 32'h1);
    align();
    rst_n = 1'b1;
    send_byte(8'h77, 1'b0, w, ov);
    send_byte(8'h88, 1'b1, w, ov);
    @(negedge clk);
    chk("t6_data", data_out0, 32'h00008877);
    chk("t6_keep", 32'(out_keep0), 32'h3);
    chk("t6_data_be", data_out1, 32'h77880000);
    align();

    // Randomized traffic with random gaps and downstream back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) align();
      send_byte(8'($urandom), ($urandom_range(0, 4) == 0), w, ov);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 Parameter BIG_ENDIAN, default 0: byte lane order within the packed word (0 = first byte in bits [7:0]; 1 = first byte in bits [31:24]).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  data_in/in_last valid this cycle.
REQ-005 in_ready  output  1  packer accepts a byte this cycle.
REQ-006 data_in  input  8  byte from upstream 8-bit datapath stage.
REQ-007 in_last  input  1  current byte ends the packet.
REQ-008 out_valid  output  1  packed word presented.
REQ-009 out_ready  input  1  downstream accepts the word.
REQ-010 data_out  output  32  packed word.
REQ-011 out_keep  output  4  per-lane byte-valid mask; bit k qualifies the lane holding the k-th byte of the word.
REQ-012 out_last  output  1  word ends a packet.

Function
REQ-013 A byte transfer occurs on a rising clk edge where in_valid && in_ready; an output transfer occurs where out_valid && out_ready.
REQ-014 in_ready = !out_valid || out_ready, combinational; no other path from inputs to outputs.
REQ-015 Internal state: 2-bit fill count (0..3), 24-bit partial-word accumulator, single output register (data_out, out_keep, out_last, out_valid).
REQ-016 On a byte transfer with count < 3 and in_last = 0: byte stored in lane count, count increments, outputs unchanged except per REQ-019.
REQ-017 On a byte transfer with count = 3 or in_last = 1 (completing transfer): output register loads accumulated bytes plus current byte, out_keep = lanes 0..count set, others clear, out_last = in_last, out_valid = 1; count returns to 0; accumulator cleared.
REQ-018 Lanes not covered by out_keep drive 0 in data_out.
REQ-019 An output transfer without a simultaneous completing transfer clears out_valid next cycle; data_out/out_keep/out_last hold their last values.
REQ-020 Output transfer and completing transfer in the same cycle: new word loads, out_valid stays 1, no bubble.
REQ-021 While out_valid && !out_ready: data_out, out_keep, out_last stable; in_ready = 0; count and accumulator frozen.
REQ-022 Latency: word visible on outputs the cycle after its completing byte is accepted; sustained throughput one byte per cycle when out_ready = 1.
REQ-023 Lane mapping: BIG_ENDIAN = 0 places byte k at data_out[8k+7:8k]; BIG_ENDIAN = 1 places it at data_out[31-8k:24-8k]; out_keep bit k follows byte k in both modes.
REQ-024 in_last on the 4th byte yields out_keep = 4'b1111, out_last = 1; single-byte packet yields out_keep = 4'b0001.
REQ-025 in_valid while in_ready = 0 has no effect; upstream holds data per valid/ready rule.

Reset
REQ-026 rst_n low forces, asynchronously: out_valid = 0, data_out = 0, out_keep = 0, out_last = 0, count = 0, accumulator = 0.
REQ-027 Reset mid-packet discards partial word and any unaccepted output word; first byte after release occupies lane 0.
REQ-028 in_ready = 1 during and immediately after reset (out_valid = 0).

Verification
REQ-029 Bench covers:
- BIG_ENDIAN=0, out_ready=1, bytes 11,22,33,44 (last on 44) back-to-back -> one cycle after 44: data_out = 0x44332211, out_keep = 1111, out_last = 1, in_ready never drops.
- BIG_ENDIAN=1, bytes AA,BB,CC with last on CC -> data_out = 0xAABBCC00, out_keep = 0111, out_last = 1.
- 8 bytes 01..08 with out_ready held 0 after first word -> word 0x04030201 held stable, in_ready = 0 until out_ready = 1; second word 0x08070605 follows with no loss.
- Single byte 5A with in_last -> data_out = 0x0000005A, out_keep = 0001, out_last = 1.
- Completing byte accepted on same edge as output handshake -> out_valid stays 1, new word replaces old with no idle cycle.
- rst_n pulsed low after 2 bytes of a packet -> all outputs 0 immediately; next bytes 77,88 (last on 88) -> data_out = 0x00008877, out_keep = 0011.
